// File: rtl/pp_pipeline_accel_m2a_pkg.sv
// Purpose: shared types and constants for the mat-stream to AXI-stream packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: the FSM state enum, pixel/word geometry, lane counter width and the
// width of the rows/cols geometry scalars.
package pp_pipeline_accel_m2a_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 64;
  localparam int PIX_PER_WORD = WORD_W / PIX_W;
  localparam int LANE_W       = 3;
  localparam int GEOM_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL1,
    ST_MUL2,
    ST_CHECK,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pp_pipeline_accel_m2a_packer.sv
// Purpose: packs 8-bit pixels LSB-first into 64-bit words behind a registered output stage.
// Latency: a word is presented one cycle after its last pixel is accepted.
// Backpressure: out_dat holds while out_vld & ~out_rdy; the caller must not offer pixels then.
// Ports: ap_clk/ap_rst_n clock and async active-low reset; clr restarts lane 0;
// pix_vld/pix_dat/pix_last pixel input; out_vld/out_dat/out_rdy word output.
// Optional: PP_PIPELINE_ACCEL_M2A_TLAST_EN adds out_last, registered with out_dat.
module pp_pipeline_accel_m2a_packer
  import pp_pipeline_accel_m2a_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              clr,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix_dat,
  input  logic              pix_last,
  input  logic              out_rdy,
  output logic              out_vld,
  output logic [WORD_W-1:0] out_dat
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
  ,output logic             out_last
`endif
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_nxt;
  logic              word_done;

  always_comb begin
    asm_nxt   = asm_q | (WORD_W'(pix_dat) << (int'(lane) * PIX_W));
    // A short final word closes early; its unused upper lanes stay zero.
    word_done = (lane == LANE_W'(PIX_PER_WORD - 1)) || pix_last;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lane     <= '0;
      asm_q    <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
      out_last <= 1'b0;
`endif
    end else begin
      // Drain first; a refill in the same cycle below takes precedence.
      if (out_vld && out_rdy) out_vld <= 1'b0;
      if (clr) begin
        lane  <= '0;
        asm_q <= '0;
      end else if (pix_vld) begin
        if (word_done) begin
          out_dat  <= asm_nxt;
          out_vld  <= 1'b1;
          asm_q    <= '0;
          lane     <= '0;
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
          out_last <= pix_last;
`endif
        end else begin
          asm_q <= asm_nxt;
          lane  <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_mat_stream_to_axi_stream.sv
// Purpose: frame-level control that packs a rows x cols pixel stream into 64-bit words.
// Latency: geometry pop to first pixel read is 4 cycles; 1 pixel/cycle sustained.
// Backpressure: ldata_full_n low with a word pending stalls pixel reads and holds ldata_din.
// Ports: ap_clk/ap_rst_n, ap_ctrl_chain (ap_start/ap_continue/ap_done/ap_idle/ap_ready),
// rows/cols scalar FIFO reads, img pixel FIFO read, ldata word FIFO write.
// Optional: PP_PIPELINE_ACCEL_M2A_TLAST_EN adds ldata_last marking the frame's final word.
module pp_pipeline_accel_mat_stream_to_axi_stream
  import pp_pipeline_accel_m2a_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [GEOM_W-1:0] rows_dout,
  input  logic              rows_empty_n,
  output logic              rows_read,
  input  logic [GEOM_W-1:0] cols_dout,
  input  logic              cols_empty_n,
  output logic              cols_read,
  input  logic [PIX_W-1:0]  img_dout,
  input  logic              img_empty_n,
  output logic              img_read,
  output logic [WORD_W-1:0] ldata_din,
  input  logic              ldata_full_n,
  output logic              ldata_write
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
  ,output logic             ldata_last
`endif
);

  state_t                    state;
  logic                      done_reg;
  logic signed [GEOM_W-1:0]  rows_q;
  logic signed [GEOM_W-1:0]  cols_q;
  logic        [GEOM_W-1:0]  op_a;
  logic        [GEOM_W-1:0]  op_b;
  logic        [GEOM_W-1:0]  total;
  logic        [GEOM_W-1:0]  pix_cnt;
  logic                      start_fire;
  logic                      out_stall;
  logic                      pix_last;

  assign start_fire = (state == ST_IDLE) && ap_start && rows_empty_n && cols_empty_n && !done_reg;
  assign rows_read  = start_fire;
  assign cols_read  = start_fire;
  assign out_stall  = ldata_write && !ldata_full_n;
  assign img_read   = (state == ST_RUN) && img_empty_n && !out_stall;
  assign pix_last   = (pix_cnt == GEOM_W'(1));
  assign ap_ready   = (state == ST_DONE);
  assign ap_done    = ap_ready || done_reg;
  assign ap_idle    = (state == ST_IDLE) && !ap_start;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= ST_IDLE;
      done_reg <= 1'b0;
      rows_q   <= '0;
      cols_q   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      total    <= '0;
      pix_cnt  <= '0;
    end else begin
      if (ap_continue) done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_fire) begin
            rows_q <= rows_dout;
            cols_q <= cols_dout;
            state  <= ST_MUL1;
          end
        end
        ST_MUL1: begin
          // Non-positive geometry collapses to an empty frame.
          if (rows_q > 0 && cols_q > 0) begin
            op_a <= $unsigned(rows_q);
            op_b <= $unsigned(cols_q);
          end else begin
            op_a <= '0;
            op_b <= '0;
          end
          state <= ST_MUL2;
        end
        ST_MUL2: begin
          total <= op_a * op_b;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (total == '0) begin
            state <= ST_DONE;
          end else begin
            pix_cnt <= total;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (img_read) begin
            pix_cnt <= pix_cnt - GEOM_W'(1);
            if (pix_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!ldata_write) state <= ST_DONE;
        end
        ST_DONE: begin
          done_reg <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pp_pipeline_accel_m2a_packer u_packer (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (state == ST_CHECK),
    .pix_vld  (img_read),
    .pix_dat  (img_dout),
    .pix_last (pix_last),
    .out_rdy  (ldata_full_n),
    .out_vld  (ldata_write),
    .out_dat  (ldata_din)
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
    ,.out_last(ldata_last)
`endif
  );

endmodule

// File: tb/tb_pp_pipeline_accel_mat_stream_to_axi_stream.sv
// Purpose: self-checking bench for the mat-stream to AXI-stream packer.
// Latency: n/a.
// Backpressure: bench models the FIFOs around the block and drives ldata_full_n.
module tb_pp_pipeline_accel_mat_stream_to_axi_stream;

  logic        ap_clk       = 1'b0;
  logic        ap_rst_n     = 1'b0;
  logic        ap_start     = 1'b0;
  logic        ap_continue  = 1'b0;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] rows_dout    = '0;
  logic        rows_empty_n = 1'b0;
  logic        rows_read;
  logic [31:0] cols_dout    = '0;
  logic        cols_empty_n = 1'b0;
  logic        cols_read;
  logic [7:0]  img_dout     = '0;
  logic        img_empty_n  = 1'b0;
  logic        img_read;
  logic [63:0] ldata_din;
  logic        ldata_full_n = 1'b1;
  logic        ldata_write;
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
  logic        ldata_last;
`endif

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_mat_stream_to_axi_stream dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_continue  (ap_continue),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .rows_dout    (rows_dout),
    .rows_empty_n (rows_empty_n),
    .rows_read    (rows_read),
    .cols_dout    (cols_dout),
    .cols_empty_n (cols_empty_n),
    .cols_read    (cols_read),
    .img_dout     (img_dout),
    .img_empty_n  (img_empty_n),
    .img_read     (img_read),
    .ldata_din    (ldata_din),
    .ldata_full_n (ldata_full_n),
    .ldata_write  (ldata_write)
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
    ,.ldata_last  (ldata_last)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO contents, expected and captured words
  int          rows_q[$];
  int          cols_q[$];
  logic [7:0]  img_q[$];
  logic [7:0]  preset_q[$];
  logic [63:0] exp_dat[$];
  logic [63:0] got_dat[$];
  logic        exp_last[$];
  logic        got_last[$];

  int cyc = 0, rows_pops = 0, cols_pops = 0, img_pops = 0, ready_pulses = 0;
  int pop_cyc = 0, ready_cyc = 0, first_img_cyc = -1, last_img_cyc = -1, first_wr_cyc = -1;
  int fn_mode = 0;  // 0: always ready, 1: random, 2: one 5-cycle stall on the first word
  int stall_left = 0, stall_cycles = 0;
  bit stall_used = 1'b0, was_stalled = 1'b0;
  bit pend_rows = 1'b0, pend_cols = 1'b0, pend_img = 1'b0;
  logic [63:0] held_din = '0;

  // Environment: update FIFO/sink drive on the falling edge, sample DUT 1 ns later.
  always @(negedge ap_clk) begin
    cyc++;
    if (pend_rows && rows_q.size() > 0) void'(rows_q.pop_front());
    if (pend_cols && cols_q.size() > 0) void'(cols_q.pop_front());
    if (pend_img  && img_q.size()  > 0) void'(img_q.pop_front());
    rows_empty_n = (rows_q.size() > 0);
    rows_dout    = rows_empty_n ? 32'(rows_q[0]) : 32'h0;
    cols_empty_n = (cols_q.size() > 0);
    cols_dout    = cols_empty_n ? 32'(cols_q[0]) : 32'h0;
    img_empty_n  = (img_q.size() > 0) && (fn_mode != 1 || $urandom_range(3) != 0);
    img_dout     = (img_q.size() > 0) ? img_q[0] : 8'h00;
    if (fn_mode == 2 && !stall_used && ldata_write) begin
      stall_left = 5;
      stall_used = 1'b1;
    end
    if (fn_mode == 1) begin
      ldata_full_n = ($urandom_range(3) != 0);
    end else begin
      ldata_full_n = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
    #1;
    pend_rows = rows_read;
    pend_cols = cols_read;
    pend_img  = img_read;
    if (rows_read) begin rows_pops++; pop_cyc = cyc; end
    if (cols_read) cols_pops++;
    if (img_read) begin
      if (!img_empty_n) chk("img_read_on_empty", 64'(img_read), 64'(0));
      img_pops++;
      if (first_img_cyc < 0) first_img_cyc = cyc;
      last_img_cyc = cyc;
    end
    if (ldata_write && first_wr_cyc < 0) first_wr_cyc = cyc;
    if (ldata_write && ldata_full_n) begin
      got_dat.push_back(ldata_din);
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
      got_last.push_back(ldata_last);
`else
      got_last.push_back(1'b0);
`endif
    end
    if (ldata_write && !ldata_full_n) begin
      stall_cycles++;
      chk("stall_no_img_read", 64'(img_read), 64'(0));
      if (was_stalled) chk("stall_din_stable", ldata_din, held_din);
      held_din = ldata_din;
    end
    was_stalled = ldata_write && !ldata_full_n;
    if (ap_ready) begin ready_pulses++; ready_cyc = cyc; end
  end

  // Queue geometry and pixels; build the expected words from the packing rule.
  task automatic prep_frame(input int r, input int c);
    int total;
    int nw;
    logic [7:0]  pix[$];
    logic [63:0] wd;
    logic [7:0]  p;
    total = (r > 0 && c > 0) ? r * c : 0;
    for (int i = 0; i < total; i++) begin
      p = (i < preset_q.size()) ? preset_q[i] : 8'($urandom);
      pix.push_back(p);
      img_q.push_back(p);
    end
    preset_q.delete();
    exp_dat.delete(); exp_last.delete(); got_dat.delete(); got_last.delete();
    nw = (total + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      for (int k = 0; k < 8; k++)
        if (8 * w + k < total) wd[8 * k +: 8] = pix[8 * w + k];
      exp_dat.push_back(wd);
      exp_last.push_back(w == nw - 1);
    end
    first_img_cyc = -1; first_wr_cyc = -1; stall_cycles = 0; stall_used = 1'b0;
    rows_q.push_back(r);
    cols_q.push_back(c);
  endtask

  task automatic go_frame(input bit hold);
    int r0;
    int n;
    r0 = ready_pulses;
    n  = 0;
    ap_start = 1'b1;
    while (ready_pulses == r0 && n < 3000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("done_seen", 64'(ready_pulses != r0), 64'(1));
    ap_start = 1'b0;
    if (!hold) begin
      ap_continue = 1'b1;
      @(negedge ap_clk);
      ap_continue = 1'b0;
    end
    @(negedge ap_clk);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nwords"}, 64'(got_dat.size()), 64'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (i < got_dat.size()) begin
        chk({tag, "_word"}, got_dat[i], exp_dat[i]);
`ifdef PP_PIPELINE_ACCEL_M2A_TLAST_EN
        chk({tag, "_last"}, 64'(got_last[i]), 64'(exp_last[i]));
`endif
      end
    end
  endtask

  initial begin
    int r0, rp0, cp0, ip0, n, rr, cc;
    int geo_r[2];
    int geo_c[2];
    geo_r[0] = 0;  geo_c[0] = 100;
    geo_r[1] = -1; geo_c[1] = 5;

    repeat (3) @(negedge ap_clk);
    chk("rst_ldata_write", 64'(ldata_write), 64'(0));
    chk("rst_ldata_din",   ldata_din,        64'(0));
    chk("rst_img_read",    64'(img_read),    64'(0));
    chk("rst_rows_read",   64'(rows_read),   64'(0));
    chk("rst_ap_done",     64'(ap_done),     64'(0));
    chk("rst_ap_ready",    64'(ap_ready),    64'(0));
    chk("rst_ap_idle",     64'(ap_idle),     64'(1));
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // 2x8 ramp: latency, throughput and word layout
    for (int i = 0; i < 16; i++) preset_q.push_back(8'(i));
    r0 = ready_pulses;
    prep_frame(2, 8);
    go_frame(1'b0);
    check_frame("ramp");
    chk("ramp_done_pulses", 64'(ready_pulses - r0), 64'(1));
    chk("ramp_pop_to_img",  64'(first_img_cyc - pop_cyc), 64'(4));
    chk("ramp_img_to_word", 64'(first_wr_cyc - first_img_cyc), 64'(8));
    chk("ramp_throughput",  64'(last_img_cyc - first_img_cyc), 64'(15));

    // Partial word
    preset_q.push_back(8'hAA); preset_q.push_back(8'hBB); preset_q.push_back(8'hCC);
    prep_frame(1, 3);
    go_frame(1'b0);
    check_frame("part");
    chk("part_word_value", (got_dat.size() > 0) ? got_dat[0] : 64'hDEAD, 64'h0000_0000_00CC_BBAA);

    // Output back-pressure on the first word
    fn_mode = 2;
    prep_frame(1, 16);
    go_frame(1'b0);
    check_frame("stall");
    chk("stall_cycles", 64'(stall_cycles), 64'(5));
    fn_mode = 0;

    // Empty frames
    for (int g = 0; g < 2; g++) begin
      rp0 = rows_pops; cp0 = cols_pops; ip0 = img_pops;
      prep_frame(geo_r[g], geo_c[g]);
      go_frame(1'b0);
      check_frame("empty");
      chk("empty_rows_pop", 64'(rows_pops - rp0), 64'(1));
      chk("empty_cols_pop", 64'(cols_pops - cp0), 64'(1));
      chk("empty_img_read", 64'(img_pops - ip0),  64'(0));
      chk("empty_no_write", 64'(first_wr_cyc),    64'(-1));
      chk("empty_done_lat", 64'(ready_cyc - pop_cyc <= 5), 64'(1));
    end

    // Held done blocks the next frame until ap_continue
    prep_frame(1, 4);
    go_frame(1'b1);
    check_frame("hold1");
    chk("hold_done_held", 64'(ap_done), 64'(1));
    rp0 = rows_pops;
    prep_frame(1, 8);
    ap_start = 1'b1;
    repeat (10) @(negedge ap_clk);
    chk("hold_no_pop",     64'(rows_pops - rp0), 64'(0));
    chk("hold_done_still", 64'(ap_done), 64'(1));
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    go_frame(1'b0);
    check_frame("hold2");
    chk("hold_pop_after", 64'(rows_pops - rp0), 64'(1));

    // Reset mid-frame after 5 of 8 pixels
    prep_frame(1, 8);
    ip0 = img_pops;
    n = 0;
    ap_start = 1'b1;
    while (img_pops - ip0 < 5 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("abort_reached", 64'(img_pops - ip0), 64'(5));
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    #2;
    chk("abort_img_read",    64'(img_read),    64'(0));
    chk("abort_ldata_write", 64'(ldata_write), 64'(0));
    chk("abort_ldata_din",   ldata_din,        64'(0));
    chk("abort_ap_done",     64'(ap_done),     64'(0));
    chk("abort_rows_read",   64'(rows_read),   64'(0));
    repeat (2) @(negedge ap_clk);
    img_q.delete();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    prep_frame(1, 8);
    go_frame(1'b0);
    check_frame("after_rst");

    // Random geometry, random pixel availability and output readiness
    fn_mode = 1;
    for (int f = 0; f < 6; f++) begin
      rr = $urandom_range(3, 1);
      cc = $urandom_range(24, 1);
      prep_frame(rr, cc);
      go_frame(1'b0);
      check_frame("rnd");
    end
    fn_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
